// File: rtl/button_input.sv
// button_input
// Conditions raw push-button pins into clean signals that are synchronous to CLK.
// Each channel has the same datapath, independent of the others:
// polarity normalisation, a 2-flop synchronizer, a counter-based debounce,
// a registered debounced level and registered one-cycle press/release pulses.
//
// Optional feature macro: BUTTON_INPUT_LONG_PRESS_EN
//   When it is defined, the block gains a LONG_BITS parameter and a LONG output.
//   LONG gives a single one-cycle pulse for each press that has been held
//   for 2^LONG_BITS-1 cycles after PRESS.
//
// Ports:
//   CLK      in   system clock
//   RST      in   synchronous reset, active-high
//   BTN      in   [N_BUTTONS] raw asynchronous button pins
//   STATE    out  [N_BUTTONS] debounced level, 1 = pressed
//   PRESS    out  [N_BUTTONS] one-cycle pulse on a debounced 0->1 transition
//   RELEASE  out  [N_BUTTONS] one-cycle pulse on a debounced 1->0 transition
//   LONG     out  [N_BUTTONS] one-cycle long-press pulse (macro builds only)
module button_input #(
    parameter int N_BUTTONS     = 3,
    parameter int DEBOUNCE_BITS = 16,
    parameter int ACTIVE_LOW    = 0
`ifdef BUTTON_INPUT_LONG_PRESS_EN
    ,
    parameter int LONG_BITS     = 24
`endif
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_BUTTONS-1:0] BTN,
    output logic [N_BUTTONS-1:0] STATE,
    output logic [N_BUTTONS-1:0] PRESS,
    output logic [N_BUTTONS-1:0] RELEASE
`ifdef BUTTON_INPUT_LONG_PRESS_EN
    ,
    output logic [N_BUTTONS-1:0] LONG
`endif
);

    localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;
    localparam logic [DEBOUNCE_BITS-1:0] DB_ONE = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

    logic [N_BUTTONS-1:0]     raw;
    logic [N_BUTTONS-1:0]     s1_q, s1_d;
    logic [N_BUTTONS-1:0]     s2_q, s2_d;
    logic [N_BUTTONS-1:0]     state_q, state_d;
    logic [N_BUTTONS-1:0]     press_q, press_d;
    logic [N_BUTTONS-1:0]     release_q, release_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q [N_BUTTONS];
    logic [DEBOUNCE_BITS-1:0] cnt_d [N_BUTTONS];

    // Normalise polarity so that 1 always means pressed. The reset value 0
    // of the synchronizer is then the inactive level for either polarity.
    always_comb begin
        raw = (ACTIVE_LOW != 0) ? ~BTN : BTN;
    end

    // Synchronizer stage
    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
    end

    // Debounce stage: the counter measures how long s2 has disagreed with
    // STATE without a break. Any agreement clears it, which rejects glitches.
    // The pulses are computed together with the new level so that they
    // register on the same edge as STATE.
    always_comb begin
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_MAX) begin
                cnt_d[i]     = '0;
                state_d[i]   = s2_q[i];
                press_d[i]   = s2_q[i];
                release_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + DB_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q      <= '0;
            s2_q      <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign STATE   = state_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;

`ifdef BUTTON_INPUT_LONG_PRESS_EN
    localparam logic [LONG_BITS-1:0] HOLD_MAX = '1;

    // Increment that stops at all-ones, so a held button never wraps around
    // and cannot produce a second LONG pulse.
    function automatic logic [LONG_BITS-1:0] sat_inc(input logic [LONG_BITS-1:0] v);
        logic [LONG_BITS-1:0] r;
        r = (v == HOLD_MAX) ? v : v + {{(LONG_BITS-1){1'b0}}, 1'b1};
        return r;
    endfunction

    logic [N_BUTTONS-1:0] long_q, long_d;
    logic [LONG_BITS-1:0] hold_q [N_BUTTONS];
    logic [LONG_BITS-1:0] hold_d [N_BUTTONS];

    // Long-press stage: the hold counter is 0 on the PRESS edge and counts
    // one per cycle afterwards. LONG fires only on the cycle where the
    // counter first reaches saturation.
    always_comb begin
        long_d = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (!state_d[i] || press_d[i]) begin
                hold_d[i] = '0;
            end else begin
                hold_d[i] = sat_inc(hold_q[i]);
            end
            long_d[i] = state_d[i] && !press_d[i] &&
                        (hold_d[i] == HOLD_MAX) && (hold_q[i] != HOLD_MAX);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            long_q <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            long_q <= long_d;
            for (int i = 0; i < N_BUTTONS; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign LONG = long_q;
`endif

endmodule

// File: tb/tb_button_input.sv
module tb_button_input;

    localparam int NB  = 3;
    localparam int DB  = 2;
    localparam int WIN = 1 << DB;   // cycles the new level must be seen at s2
    localparam int LB  = 4;
    localparam int LONG_AFTER = (1 << LB) - 1;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn;
    logic [NB-1:0] btn_n;
    logic [NB-1:0] st0, pr0, rl0;
    logic [NB-1:0] st1, pr1, rl1;
`ifdef BUTTON_INPUT_LONG_PRESS_EN
    logic [NB-1:0] lg0, lg1;
`endif

    int checks   = 0;
    int failures = 0;

    assign btn_n = ~btn;

    // Active-high instance and active-low instance driven with inverted pins;
    // both must produce identical outputs.
    button_input #(.N_BUTTONS(NB), .DEBOUNCE_BITS(DB), .ACTIVE_LOW(0)
`ifdef BUTTON_INPUT_LONG_PRESS_EN
        , .LONG_BITS(LB)
`endif
    ) dut0 (
        .CLK(clk), .RST(rst), .BTN(btn),
        .STATE(st0), .PRESS(pr0), .RELEASE(rl0)
`ifdef BUTTON_INPUT_LONG_PRESS_EN
        , .LONG(lg0)
`endif
    );

    button_input #(.N_BUTTONS(NB), .DEBOUNCE_BITS(DB), .ACTIVE_LOW(1)
`ifdef BUTTON_INPUT_LONG_PRESS_EN
        , .LONG_BITS(LB)
`endif
    ) dut1 (
        .CLK(clk), .RST(rst), .BTN(btn_n),
        .STATE(st1), .PRESS(pr1), .RELEASE(rl1)
`ifdef BUTTON_INPUT_LONG_PRESS_EN
        , .LONG(lg1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the pin level reaches the debouncer two edges after it
    // is sampled. The level flips once the last WIN samples seen since the
    // previous flip all disagree with it.
    logic [NB-1:0] exp_state, exp_press, exp_release, exp_long;
    logic [NB-1:0] dly1, dly2;
    bit            hist [NB][$];
    int            held [NB];

    always @(posedge clk) begin
        logic [NB-1:0] samp;
        bit            all_diff;
        if (rst) begin
            dly1 = '0; dly2 = '0;
            exp_state = '0; exp_press = '0; exp_release = '0; exp_long = '0;
            for (int c = 0; c < NB; c++) begin
                hist[c].delete();
                held[c] = 0;
            end
        end else begin
            samp = dly2;
            dly2 = dly1;
            dly1 = btn;
            exp_press = '0; exp_release = '0; exp_long = '0;
            for (int c = 0; c < NB; c++) begin
                hist[c].push_back(samp[c]);
                all_diff = (hist[c].size() >= WIN);
                for (int k = 0; k < WIN && all_diff; k++)
                    if (hist[c][hist[c].size()-1-k] == exp_state[c]) all_diff = 0;
                if (all_diff) begin
                    exp_state[c] = ~exp_state[c];
                    if (exp_state[c]) exp_press[c] = 1'b1;
                    else              exp_release[c] = 1'b1;
                    hist[c].delete();
                end
                if (!exp_state[c] || exp_press[c]) held[c] = 0;
                else begin
                    held[c]++;
                    if (held[c] == LONG_AFTER) exp_long[c] = 1'b1;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        btn = 3'b111;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            checks++;
            if ({st0, pr0, rl0, st1, pr1, rl1} !== 18'd0) begin
                failures++;
                $display("FAIL reset_outputs cyc=%0d got st=%b pr=%b rl=%b / st=%b pr=%b rl=%b want all 0",
                         j, st0, pr0, rl0, st1, pr1, rl1);
            end
        end
        rst = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checks++;
            if (pr0 !== ((j == 5) ? 3'b111 : 3'b000) || pr1 !== pr0) begin
                failures++;
                $display("FAIL reset_release_press j=%0d got %b/%b want %b", j, pr0, pr1,
                         (j == 5) ? 3'b111 : 3'b000);
            end
            checks++;
            if ({st0, pr0, rl0} !== {exp_state, exp_press, exp_release}) begin
                failures++;
                $display("FAIL reset_model j=%0d got %b want %b", j, {st0, pr0, rl0},
                         {exp_state, exp_press, exp_release});
            end
        end
    endtask

    task automatic test_clean_press();
        btn = 3'b000;
        repeat (12) @(negedge clk);
        btn[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checks++;
            if (st0[0] !== (j >= 5) || pr0[0] !== (j == 5) || st1[0] !== st0[0] || pr1[0] !== pr0[0]) begin
                failures++;
                $display("FAIL clean_press j=%0d got st=%b pr=%b (al st=%b pr=%b) want st=%b pr=%b",
                         j, st0[0], pr0[0], st1[0], pr1[0], (j >= 5), (j == 5));
            end
        end
    endtask

    task automatic test_bounce();
        for (int j = 0; j < 20; j++) begin
            btn[1] = (j % 2 == 0);
            @(negedge clk);
            checks++;
            if (pr0[1] !== 1'b0 || st0[1] !== 1'b0 || pr1[1] !== 1'b0 || st1[1] !== 1'b0) begin
                failures++;
                $display("FAIL bounce j=%0d got pr=%b st=%b (al pr=%b st=%b) want 0 0",
                         j, pr0[1], st0[1], pr1[1], st1[1]);
            end
        end
        btn[1] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            checks++;
            if (pr0[1] !== (j == 5) || pr1[1] !== (j == 5)) begin
                failures++;
                $display("FAIL bounce_settle j=%0d got %b/%b want %b", j, pr0[1], pr1[1], (j == 5));
            end
        end
    endtask

    task automatic test_release();
        btn[2] = 1'b1;
        repeat (10) @(negedge clk);
        btn[2] = 1'b0;
        for (int j = 0; j < 9; j++) begin
            @(negedge clk);
            checks++;
            if (rl0[2] !== (j == 5) || st0[2] !== (j < 5) || pr0[2] !== 1'b0 ||
                rl1[2] !== (j == 5) || st1[2] !== (j < 5) || pr1[2] !== 1'b0) begin
                failures++;
                $display("FAIL release j=%0d got rl=%b st=%b pr=%b (al rl=%b st=%b pr=%b) want rl=%b st=%b pr=0",
                         j, rl0[2], st0[2], pr0[2], rl1[2], st1[2], pr1[2], (j == 5), (j < 5));
            end
        end
    endtask

    task automatic test_simultaneous();
        btn = 3'b000;
        repeat (12) @(negedge clk);
        btn = 3'b101;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            checks++;
            if (pr0 !== ((j == 5) ? 3'b101 : 3'b000) || pr1 !== pr0) begin
                failures++;
                $display("FAIL simultaneous j=%0d got %b/%b want %b", j, pr0, pr1,
                         (j == 5) ? 3'b101 : 3'b000);
            end
        end
    endtask

`ifdef BUTTON_INPUT_LONG_PRESS_EN
    task automatic test_long();
        btn = 3'b000;
        repeat (12) @(negedge clk);
        btn = 3'b001;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            checks++;
            if (lg0 !== ((j == 5 + LONG_AFTER) ? 3'b001 : 3'b000) || lg1 !== lg0) begin
                failures++;
                $display("FAIL long_hold j=%0d got %b/%b want %b", j, lg0, lg1,
                         (j == 5 + LONG_AFTER) ? 3'b001 : 3'b000);
            end
        end
        btn = 3'b000;
        repeat (12) @(negedge clk);
        btn = 3'b001;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 12) btn = 3'b000;
            checks++;
            if (lg0 !== 3'b000 || lg1 !== 3'b000) begin
                failures++;
                $display("FAIL long_short j=%0d got %b/%b want 000", j, lg0, lg1);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int j = 0; j < 1500; j++) begin
            @(negedge clk);
            checks++;
            if ({st0, pr0, rl0} !== {exp_state, exp_press, exp_release} ||
                {st1, pr1, rl1} !== {exp_state, exp_press, exp_release}) begin
                failures++;
                $display("FAIL random j=%0d got %b al %b want %b", j, {st0, pr0, rl0},
                         {st1, pr1, rl1}, {exp_state, exp_press, exp_release});
            end
`ifdef BUTTON_INPUT_LONG_PRESS_EN
            checks++;
            if (lg0 !== exp_long || lg1 !== exp_long) begin
                failures++;
                $display("FAIL random_long j=%0d got %b/%b want %b", j, lg0, lg1, exp_long);
            end
`endif
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 5) == 0) btn[$urandom_range(0, NB-1)] ^= 1'b1;
            // Occasionally hold the pins still long enough for levels to settle.
            if ($urandom_range(0, 99) == 0) repeat ($urandom_range(4, 20)) begin
                @(negedge clk);
                rst = 1'b0;
                checks++;
                if ({st0, pr0, rl0} !== {exp_state, exp_press, exp_release}) begin
                    failures++;
                    $display("FAIL random_hold j=%0d got %b want %b", j, {st0, pr0, rl0},
                             {exp_state, exp_press, exp_release});
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        btn = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
`ifdef BUTTON_INPUT_LONG_PRESS_EN
        test_long();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
